// File: rtl/program_loader_pkg.sv
// Shared types and constants for the boot-time program loader.
package loader_pkg;

    // Loader FSM states
    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_HI,
        S_LEN_LO,
        S_DATA,
        S_CHK,
        S_RUN,
        S_FAIL
    } state_t;

    // Default instruction-memory word-address width and the depth it implies
    localparam int DEF_ADDR_W = 8;
    localparam int MAX_WORDS  = 1 << DEF_ADDR_W;

    // Byte position within a big-endian word (0 = MSB, 3 = LSB)
    localparam logic [1:0] BYTE_IDX_FIRST = 2'd0;
    localparam logic [1:0] BYTE_IDX_LAST  = 2'd3;

    // Largest legal word count for a given address width
    function automatic logic [16:0] max_words(input int addr_w);
        return 17'd1 << addr_w;
    endfunction

endpackage

// File: rtl/program_loader_if.sv
// Byte-stream input and instruction-memory write port of the loader.
interface program_loader_if #(
    parameter int ADDR_W = 8
);
    logic [7:0]        RX_DATA;
    logic              RX_VALID;
    logic              RX_READY;
    logic              IM_WE;
    logic [ADDR_W-1:0] IM_ADDR;
    logic [31:0]       IM_WDATA;

    // Environment side: sources bytes, observes memory writes
    modport master (
        output RX_DATA, RX_VALID,
        input  RX_READY, IM_WE, IM_ADDR, IM_WDATA
    );

    // Loader side: sinks bytes, drives memory writes
    modport slave (
        input  RX_DATA, RX_VALID,
        output RX_READY, IM_WE, IM_ADDR, IM_WDATA
    );
endinterface

// File: rtl/program_loader_word_packer.sv
// Assembles four MSB-first bytes into a 32-bit word; flags the 4th byte.
module word_packer
    import loader_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_clr,
    input  logic        i_byte_vld,
    input  logic [7:0]  i_byte,
    output logic [31:0] o_word,
    output logic        o_word_vld
);

    logic [1:0]  r_cnt;
    logic [23:0] r_shift;

    // Shift accepted bytes in and track the position within the current word
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt   <= BYTE_IDX_FIRST;
            r_shift <= '0;
        end else if (i_clr) begin
            r_cnt   <= BYTE_IDX_FIRST;
            r_shift <= '0;
        end else if (i_byte_vld) begin
            r_cnt   <= r_cnt + 2'd1;
            r_shift <= {r_shift[15:0], i_byte};
        end
    end

    // The word completes combinationally with its last byte
    assign o_word     = {r_shift, i_byte};
    assign o_word_vld = i_byte_vld && (r_cnt == BYTE_IDX_LAST);

endmodule

// File: rtl/program_loader.sv
// Boot loader: receives a framed byte stream, writes words to instruction
// memory from address 0 and holds the CPU in reset until a good checksum.
module program_loader
    import loader_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic             CLK,
    input  logic             RSTN,
    input  logic             START,
    program_loader_if.slave  bus,
    output logic             CPU_RST,
    output logic             BUSY,
    output logic             DONE,
    output logic             ERR
);

    localparam logic [16:0] MAX_N = max_words(ADDR_W);

    state_t            r_state;
    state_t            w_next;
    logic              w_rx_ready;
    logic              w_accept;
    logic              w_start_ok;
    logic [15:0]       w_len;
    logic              w_len_bad;
    logic              w_last_word;
    logic [31:0]       w_word;
    logic              w_word_vld;
    logic              w_cpu_rst_nxt;
    logic              w_busy_nxt;
    logic              w_done_nxt;
    logic              w_err_nxt;

    logic [7:0]        r_len_hi;
    logic [15:0]       r_len;
    logic [7:0]        r_xor;
    logic [16:0]       r_wcnt;
    logic [ADDR_W-1:0] r_addr;
    logic              r_im_we;
    logic [ADDR_W-1:0] r_im_addr;
    logic [31:0]       r_im_wdata;
    logic              r_cpu_rst;
    logic              r_busy;
    logic              r_done;
    logic              r_err;

    assign w_accept    = bus.RX_VALID && w_rx_ready;
    assign w_start_ok  = START && (r_state == S_IDLE || r_state == S_RUN || r_state == S_FAIL);
    assign w_len       = {r_len_hi, bus.RX_DATA};
    assign w_len_bad   = (w_len == 16'd0) || ({1'b0, w_len} > MAX_N);
    assign w_last_word = w_word_vld && ((r_wcnt + 17'd1) == {1'b0, r_len});

    word_packer u_packer (
        .i_clk      (CLK),
        .i_rst_n    (RSTN),
        .i_clr      (w_start_ok),
        .i_byte_vld (w_accept && (r_state == S_DATA)),
        .i_byte     (bus.RX_DATA),
        .o_word     (w_word),
        .o_word_vld (w_word_vld)
    );

    // FSM state register
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    // FSM next-state decode
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (START)       w_next = S_LEN_HI;
            S_LEN_HI: if (w_accept)    w_next = S_LEN_LO;
            S_LEN_LO: if (w_accept)    w_next = w_len_bad ? S_FAIL : S_DATA;
            S_DATA:   if (w_last_word) w_next = S_CHK;
            S_CHK:    if (w_accept)    w_next = (bus.RX_DATA == r_xor) ? S_RUN : S_FAIL;
            S_RUN,
            S_FAIL:   if (START)       w_next = S_LEN_HI;
            default:                   w_next = S_IDLE;
        endcase
    end

    // FSM outputs: ready decoded from current state, status from next state
    always_comb begin
        w_rx_ready    = (r_state == S_LEN_HI) || (r_state == S_LEN_LO) ||
                        (r_state == S_DATA)   || (r_state == S_CHK);
        w_busy_nxt    = (w_next == S_LEN_HI) || (w_next == S_LEN_LO) ||
                        (w_next == S_DATA)   || (w_next == S_CHK);
        w_done_nxt    = (w_next == S_RUN);
        w_err_nxt     = (w_next == S_FAIL);
        w_cpu_rst_nxt = (w_next != S_RUN);
    end

    // Registered status flags
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            r_cpu_rst <= 1'b1;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_cpu_rst <= w_cpu_rst_nxt;
            r_busy    <= w_busy_nxt;
            r_done    <= w_done_nxt;
            r_err     <= w_err_nxt;
        end
    end

    // Frame bookkeeping: length, running XOR, word count and write address
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            r_len_hi <= '0;
            r_len    <= '0;
            r_xor    <= '0;
            r_wcnt   <= '0;
            r_addr   <= '0;
        end else if (w_start_ok) begin
            r_xor  <= '0;
            r_wcnt <= '0;
            r_addr <= '0;
        end else begin
            if (w_accept && r_state != S_CHK) r_xor <= r_xor ^ bus.RX_DATA;
            if (w_accept && r_state == S_LEN_HI) r_len_hi <= bus.RX_DATA;
            if (w_accept && r_state == S_LEN_LO) r_len <= w_len;
            if (w_word_vld) begin
                r_wcnt <= r_wcnt + 17'd1;
                // A full-depth image leaves the address parked on the last word
                if (r_addr != '1) r_addr <= r_addr + 1'b1;
            end
        end
    end

    // Instruction-memory write port, one strobe per completed word
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            r_im_we    <= 1'b0;
            r_im_addr  <= '0;
            r_im_wdata <= '0;
        end else begin
            r_im_we <= w_word_vld;
            if (w_word_vld) begin
                r_im_addr  <= r_addr;
                r_im_wdata <= w_word;
            end
        end
    end

    assign bus.RX_READY = w_rx_ready;
    assign bus.IM_WE    = r_im_we;
    assign bus.IM_ADDR  = r_im_addr;
    assign bus.IM_WDATA = r_im_wdata;
    assign CPU_RST      = r_cpu_rst;
    assign BUSY         = r_busy;
    assign DONE         = r_done;
    assign ERR          = r_err;

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader with a write scoreboard.
module tb_program_loader;

    localparam int AW = 8;

    logic CLK = 1'b0;
    logic RSTN;
    logic START;
    logic CPU_RST, BUSY, DONE, ERR;

    program_loader_if #(.ADDR_W(AW)) bus ();

    program_loader #(.ADDR_W(AW)) dut (
        .CLK     (CLK),
        .RSTN    (RSTN),
        .START   (START),
        .bus     (bus),
        .CPU_RST (CPU_RST),
        .BUSY    (BUSY),
        .DONE    (DONE),
        .ERR     (ERR)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [31:0]   data;
    } wr_t;

    wr_t         exp_q[$];
    logic [7:0]  frame_q[$];
    logic [31:0] w_arr[0:255];
    int          n_tests = 0;
    int          n_fail  = 0;

    // Scoreboard: every write strobe must match the oldest expected write
    always @(negedge CLK) begin
        if (RSTN === 1'b1 && bus.IM_WE === 1'b1) begin
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_write addr=%0h data=%h required=no write", bus.IM_ADDR, bus.IM_WDATA);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                if (bus.IM_ADDR !== e.addr || bus.IM_WDATA !== e.data) begin
                    n_fail++;
                    $display("FAIL im_write got addr=%0h data=%h required addr=%0h data=%h",
                             bus.IM_ADDR, bus.IM_WDATA, e.addr, e.data);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog sim_time=%0t required=finish earlier", $time);
        $fatal(1, "watchdog");
    end

    task automatic send_byte(input logic [7:0] b);
        bit acc;
        int t;
        bus.RX_DATA  = b;
        bus.RX_VALID = 1'b1;
        acc = 1'b0;
        t   = 0;
        while (!acc && t < 100) begin
            @(negedge CLK);
            acc = bus.RX_READY;
            @(posedge CLK);
            #1;
            t++;
        end
        bus.RX_VALID = 1'b0;
        if (!acc) begin
            n_tests++;
            n_fail++;
            $display("FAIL rx_accept_timeout byte=%h ready=%b required=1", b, bus.RX_READY);
        end
    endtask

    task automatic do_start();
        START = 1'b1;
        @(posedge CLK);
        #1;
        START = 1'b0;
    endtask

    task automatic make_frame(input logic [15:0] len, input int nw, input logic [7:0] chk_flip);
        logic [7:0] x;
        frame_q.delete();
        frame_q.push_back(len[15:8]);
        frame_q.push_back(len[7:0]);
        for (int w = 0; w < nw; w++)
            for (int b = 0; b < 4; b++)
                frame_q.push_back(w_arr[w][31-8*b -: 8]);
        x = 8'h00;
        foreach (frame_q[i]) x = x ^ frame_q[i];
        frame_q.push_back(x ^ chk_flip);
    endtask

    task automatic send_frame(input int gap, input int nwrites);
        for (int i = 0; i < frame_q.size(); i++) begin
            if (i >= 2 && (i - 2) / 4 < nwrites && (i - 2) % 4 == 3)
                exp_q.push_back('{addr: AW'((i - 2) / 4), data: w_arr[(i - 2) / 4]});
            send_byte(frame_q[i]);
            if (i != frame_q.size() - 1) begin
                repeat (gap) begin
                    @(negedge CLK);
                    n_tests++;
                    if (bus.RX_READY !== 1'b1) begin
                        n_fail++;
                        $display("FAIL ready_during_stall got=%b required=1 byte_idx=%0d", bus.RX_READY, i);
                    end
                    @(posedge CLK);
                    #1;
                end
            end
        end
    endtask

    task automatic test_reset();
        RSTN = 1'b0;
        START = 1'b0;
        bus.RX_VALID = 1'b0;
        bus.RX_DATA = 8'h00;
        repeat (2) @(negedge CLK);
        n_tests++;
        if ({CPU_RST, BUSY, DONE, ERR, bus.RX_READY, bus.IM_WE} !== 6'b100000 ||
            bus.IM_ADDR !== '0 || bus.IM_WDATA !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_values got rst/busy/done/err/rdy/we=%b addr=%0h data=%h required 100000 0 0",
                     {CPU_RST, BUSY, DONE, ERR, bus.RX_READY, bus.IM_WE}, bus.IM_ADDR, bus.IM_WDATA);
        end
        @(posedge CLK);
        #1;
        RSTN = 1'b1;
        repeat (3) @(negedge CLK);
        n_tests++;
        if ({CPU_RST, BUSY, bus.RX_READY} !== 3'b100) begin
            n_fail++;
            $display("FAIL idle_hold got rst/busy/rdy=%b required=100", {CPU_RST, BUSY, bus.RX_READY});
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic set_nominal(input bit swapped);
        w_arr[0] = swapped ? 32'h01095020 : 32'h20080005;
        w_arr[1] = swapped ? 32'h20080005 : 32'h01095020;
    endtask

    task automatic test_nominal();
        set_nominal(1'b0);
        make_frame(16'd2, 2, 8'h00);
        do_start();
        n_tests++;
        if ({CPU_RST, BUSY, DONE, ERR, bus.RX_READY} !== 5'b11001) begin
            n_fail++;
            $display("FAIL start_latency got rst/busy/done/err/rdy=%b required=11001",
                     {CPU_RST, BUSY, DONE, ERR, bus.RX_READY});
        end
        send_frame(0, 2);
        n_tests++;
        if ({CPU_RST, BUSY, DONE, ERR} !== 4'b0010) begin
            n_fail++;
            $display("FAIL nominal_status got rst/busy/done/err=%b required=0010", {CPU_RST, BUSY, DONE, ERR});
        end
        repeat (2) @(negedge CLK);
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL nominal_pending_writes got=%0d required=0", exp_q.size());
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic test_bad_chk();
        set_nominal(1'b0);
        make_frame(16'd2, 2, 8'h01);
        do_start();
        send_frame(0, 2);
        n_tests++;
        if ({CPU_RST, BUSY, DONE, ERR, bus.RX_READY} !== 5'b10010) begin
            n_fail++;
            $display("FAIL bad_chk_status got rst/busy/done/err/rdy=%b required=10010",
                     {CPU_RST, BUSY, DONE, ERR, bus.RX_READY});
        end
        repeat (2) @(negedge CLK);
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL bad_chk_pending_writes got=%0d required=0", exp_q.size());
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic test_len_errors();
        logic [15:0] lens[2];
        lens[0] = 16'h0000;
        lens[1] = 16'h0101;
        for (int k = 0; k < 2; k++) begin
            do_start();
            send_byte(lens[k][15:8]);
            send_byte(lens[k][7:0]);
            n_tests++;
            if ({CPU_RST, BUSY, DONE, ERR, bus.RX_READY} !== 5'b10010) begin
                n_fail++;
                $display("FAIL len_error_%0h got rst/busy/done/err/rdy=%b required=10010",
                         lens[k], {CPU_RST, BUSY, DONE, ERR, bus.RX_READY});
            end
            repeat (4) @(posedge CLK);
            #1;
        end
    endtask

    task automatic test_stalls();
        set_nominal(1'b0);
        make_frame(16'd2, 2, 8'h00);
        do_start();
        send_frame(3, 2);
        n_tests++;
        if ({CPU_RST, BUSY, DONE, ERR} !== 4'b0010) begin
            n_fail++;
            $display("FAIL stall_status got rst/busy/done/err=%b required=0010", {CPU_RST, BUSY, DONE, ERR});
        end
        repeat (2) @(negedge CLK);
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL stall_pending_writes got=%0d required=0", exp_q.size());
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic test_max_len();
        for (int i = 0; i < 256; i++) w_arr[i] = $urandom;
        make_frame(16'd256, 256, 8'h00);
        do_start();
        send_frame(0, 256);
        n_tests++;
        if ({CPU_RST, DONE, ERR} !== 3'b010) begin
            n_fail++;
            $display("FAIL max_len_status got rst/done/err=%b required=010", {CPU_RST, DONE, ERR});
        end
        n_tests++;
        if (bus.IM_ADDR !== 8'hFF) begin
            n_fail++;
            $display("FAIL max_len_last_addr got=%0h required=ff", bus.IM_ADDR);
        end
        repeat (2) @(negedge CLK);
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL max_len_pending_writes got=%0d required=0", exp_q.size());
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset_midframe();
        set_nominal(1'b0);
        make_frame(16'd2, 2, 8'h00);
        do_start();
        exp_q.push_back('{addr: AW'(0), data: w_arr[0]});
        for (int i = 0; i < 6; i++) send_byte(frame_q[i]);
        @(negedge CLK);
        #1;
        RSTN = 1'b0;
        #1;
        n_tests++;
        if ({CPU_RST, BUSY, DONE, ERR, bus.RX_READY, bus.IM_WE} !== 6'b100000 ||
            bus.IM_ADDR !== '0 || bus.IM_WDATA !== 32'h0) begin
            n_fail++;
            $display("FAIL async_reset got rst/busy/done/err/rdy/we=%b addr=%0h data=%h required 100000 0 0",
                     {CPU_RST, BUSY, DONE, ERR, bus.RX_READY, bus.IM_WE}, bus.IM_ADDR, bus.IM_WDATA);
        end
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL midframe_pending_writes got=%0d required=0", exp_q.size());
        end
        @(posedge CLK);
        #1;
        RSTN = 1'b1;
        @(posedge CLK);
        #1;
        do_start();
        send_frame(0, 2);
        n_tests++;
        if ({CPU_RST, BUSY, DONE, ERR} !== 4'b0010) begin
            n_fail++;
            $display("FAIL post_reset_load got rst/busy/done/err=%b required=0010", {CPU_RST, BUSY, DONE, ERR});
        end
        repeat (2) @(negedge CLK);
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL post_reset_pending_writes got=%0d required=0", exp_q.size());
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reload();
        set_nominal(1'b1);
        make_frame(16'd2, 2, 8'h00);
        do_start();
        n_tests++;
        if ({CPU_RST, DONE, ERR} !== 3'b100) begin
            n_fail++;
            $display("FAIL reload_rst_reassert got rst/done/err=%b required=100", {CPU_RST, DONE, ERR});
        end
        send_frame(0, 2);
        n_tests++;
        if ({CPU_RST, BUSY, DONE, ERR} !== 4'b0010) begin
            n_fail++;
            $display("FAIL reload_status got rst/busy/done/err=%b required=0010", {CPU_RST, BUSY, DONE, ERR});
        end
        repeat (2) @(negedge CLK);
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL reload_pending_writes got=%0d required=0", exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_bad_chk();
        test_len_errors();
        test_stalls();
        test_max_len();
        test_reset_midframe();
        test_reload();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
